mipi_csi_pkt_sequencer: RTL and testbench

Packet-level controller for the 1-lane CSI-2 byte stream, running in the `clk_byte` domain between the D-PHY byte aligner and the line-buffer FIFO. It parses packet headers and tracks frame start and end. It pairs YUV422 payload bytes into 16-bit {C,Y} pixels and applies a per-frame crop window, emitting write strobes for the downstream CDC FIFO. Protocol violations are flagged without stalling the stream.

---
 rtl/mipi_csi_pkt_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_mipi_csi_pkt_sequencer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi_pkt_sequencer.sv
// CSI-2 packet sequencer: parses headers, tracks FS/FE, pairs YUV422 bytes into {C,Y} pixels
// and crops them to a window latched at frame start. Violations pulse err_* without stalling.
module mipi_csi_pkt_sequencer #(
  parameter logic [7:0] DT_YUV422 = 8'h1E,
  parameter logic [7:0] DT_FS     = 8'h00,
  parameter logic [7:0] DT_FE     = 8'h01
) (
  input  logic        clk_byte,
  input  logic        rst,
  input  logic [7:0]  byte_data0,
  input  logic        rxsync_hs0,
  input  logic        rxvalid_hs0,
  input  logic        cfg_en,
  input  logic [15:0] cfg_h_start,
  input  logic [15:0] cfg_h_width,
  input  logic [15:0] cfg_v_start,
  input  logic [15:0] cfg_v_height,
  output logic        yuv_fv,
  output logic        yuv_lv,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [15:0] line_cnt,
  output logic [15:0] frame_cnt,
  output logic        err_trunc,
  output logic        err_seq,
  output logic [2:0]  dbg_state
);

  // Stream handshake: rxsync_hs0 pulses one cycle before the DI byte; every cycle with
  // rxvalid_hs0 high carries one byte, and there is no back-pressure towards the PHY.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CRC     = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  hdr_idx_q;
  logic        crc_idx_q;
  logic [5:0]  di_q;
  logic [15:0] wc_q;
  logic [15:0] b_q;
  logic [7:0]  c_q;
  logic [15:0] sh_h_start, sh_h_width, sh_v_start, sh_v_height;

  logic        start_hdr, hdr_accept, trunc;
  logic        is_short, is_fs, is_fe, is_yuv;
  logic        last_pay, v_in_win, h_in_win;
  logic [16:0] pix_x;

  assign dbg_state = state_q;

  assign is_short = (di_q[5:4] == 2'b00);
  assign is_fs    = (di_q == DT_FS[5:0]);
  assign is_fe    = (di_q == DT_FE[5:0]);
  assign is_yuv   = (di_q == DT_YUV422[5:0]);
  assign last_pay = (b_q == wc_q - 16'd1);

  // 17-bit window compares so start + size never wraps
  assign v_in_win = ({1'b0, line_cnt} >= {1'b0, sh_v_start}) &&
                    ({1'b0, line_cnt} <  ({1'b0, sh_v_start} + {1'b0, sh_v_height}));
  assign pix_x    = {2'b00, b_q[15:1]};
  assign h_in_win = (pix_x >= {1'b0, sh_h_start}) &&
                    (pix_x <  ({1'b0, sh_h_start} + {1'b0, sh_h_width}));

  always_comb begin
    state_d    = state_q;
    start_hdr  = 1'b0;
    hdr_accept = 1'b0;
    trunc      = 1'b0;
    if (rxsync_hs0) begin
      start_hdr = 1'b1;
      trunc     = (state_q != S_IDLE);
      state_d   = S_HDR;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_HDR: begin
          if (!rxvalid_hs0) begin
            trunc   = 1'b1;
            state_d = S_IDLE;
          end else if (hdr_idx_q == 2'd3) begin
            hdr_accept = 1'b1;
            if (is_short)                state_d = S_IDLE;
            else if (is_yuv && yuv_fv)   state_d = (wc_q == 16'd0) ? S_CRC : S_PAYLOAD;
            else                         state_d = S_DROP;
          end
        end
        S_PAYLOAD: begin
          if (!rxvalid_hs0) begin
            trunc   = 1'b1;
            state_d = S_IDLE;
          end else if (last_pay) begin
            state_d = S_CRC;
          end
        end
        S_CRC: begin
          if (!rxvalid_hs0) begin
            trunc   = 1'b1;
            state_d = S_IDLE;
          end else if (crc_idx_q) begin
            state_d = S_IDLE;
          end
        end
        S_DROP:  if (!rxvalid_hs0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_byte) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk_byte) begin
    if (rst) begin
      hdr_idx_q   <= 2'd0;
      crc_idx_q   <= 1'b0;
      di_q        <= 6'd0;
      wc_q        <= 16'd0;
      b_q         <= 16'd0;
      c_q         <= 8'd0;
      sh_h_start  <= 16'd0;
      sh_h_width  <= 16'd0;
      sh_v_start  <= 16'd0;
      sh_v_height <= 16'd0;
      yuv_fv      <= 1'b0;
      yuv_lv      <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= 16'd0;
      line_cnt    <= 16'd0;
      frame_cnt   <= 16'd0;
      err_trunc   <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      err_trunc <= trunc;
      err_seq   <= 1'b0;
      if (trunc || state_q == S_CRC) yuv_lv <= 1'b0;

      if (start_hdr) begin
        hdr_idx_q <= 2'd0;
        crc_idx_q <= 1'b0;
      end else if (rxvalid_hs0) begin
        case (state_q)
          S_HDR: begin
            hdr_idx_q <= hdr_idx_q + 2'd1;
            case (hdr_idx_q)
              2'd0:    di_q       <= byte_data0[5:0];
              2'd1:    wc_q[7:0]  <= byte_data0;
              2'd2:    wc_q[15:8] <= byte_data0;
              default: ;
            endcase
          end
          S_PAYLOAD: begin
            b_q <= b_q + 16'd1;
            if (!b_q[0]) begin
              c_q <= byte_data0;
            end else begin
              // yuv_lv already encodes the vertical window for this line
              pix_valid <= cfg_en && yuv_lv && h_in_win;
              pix_data  <= {c_q, byte_data0};
            end
          end
          S_CRC:   crc_idx_q <= 1'b1;
          default: ;
        endcase
      end

      if (hdr_accept) begin
        b_q <= 16'd0;
        if (is_fs) begin
          err_seq     <= yuv_fv;
          yuv_fv      <= 1'b1;
          line_cnt    <= 16'd0;
          sh_h_start  <= cfg_h_start;
          sh_h_width  <= cfg_h_width;
          sh_v_start  <= cfg_v_start;
          sh_v_height <= cfg_v_height;
        end else if (is_fe) begin
          if (yuv_fv) begin
            yuv_fv    <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
          end else begin
            err_seq <= 1'b1;
          end
        end else if (is_yuv) begin
          if (yuv_fv) begin
            line_cnt <= line_cnt + 16'd1;
            yuv_lv   <= v_in_win && (wc_q != 16'd0);
          end else begin
            err_seq <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mipi_csi_pkt_sequencer.sv
// Self-checking bench for mipi_csi_pkt_sequencer: packet-level reference model plus a pixel
// scoreboard, directed scenarios followed by randomized frames.
module tb_mipi_csi_pkt_sequencer;

  localparam logic [7:0] DT_YUV  = 8'h1E;
  localparam logic [7:0] DT_FS   = 8'h00;
  localparam logic [7:0] DT_FE   = 8'h01;
  localparam logic [7:0] DT_RAW8 = 8'h2A;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic        clk_byte = 1'b0;
  logic        rst;
  logic [7:0]  byte_data0;
  logic        rxsync_hs0, rxvalid_hs0, cfg_en;
  logic [15:0] cfg_h_start, cfg_h_width, cfg_v_start, cfg_v_height;
  logic        yuv_fv, yuv_lv, pix_valid, err_trunc, err_seq;
  logic [15:0] pix_data, line_cnt, frame_cnt;
  logic [2:0]  dbg_state;

  mipi_csi_pkt_sequencer dut (
    .clk_byte(clk_byte), .rst(rst), .byte_data0(byte_data0),
    .rxsync_hs0(rxsync_hs0), .rxvalid_hs0(rxvalid_hs0), .cfg_en(cfg_en),
    .cfg_h_start(cfg_h_start), .cfg_h_width(cfg_h_width),
    .cfg_v_start(cfg_v_start), .cfg_v_height(cfg_v_height),
    .yuv_fv(yuv_fv), .yuv_lv(yuv_lv), .pix_valid(pix_valid), .pix_data(pix_data),
    .line_cnt(line_cnt), .frame_cnt(frame_cnt), .err_trunc(err_trunc), .err_seq(err_seq),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_byte = ~clk_byte;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0, n_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int          got_pix = 0, got_trunc = 0, got_seq = 0;
  int          exp_pix = 0, exp_trunc = 0, exp_seq = 0;

  // reference model state
  bit m_fv;
  int m_line, m_frame, m_hs, m_hw, m_vs, m_vh;
  logic fv_pre_ecc, fv_post_ecc;

  always @(negedge clk_byte) begin
    if (!rst) begin
      if (err_trunc) got_trunc++;
      if (err_seq)   got_seq++;
      if (pix_valid) begin
        got_pix++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL pix_unexpected: got %h, required no pixel", pix_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (pix_data !== mon_e) begin
            n_bad++;
            $display("FAIL pix_data: got %h, required %h", pix_data, mon_e);
          end
        end
        n_cmp++;
        if (yuv_lv !== 1'b1) begin
          n_bad++;
          $display("FAIL lv_with_pix: got %b, required 1", yuv_lv);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_byte);
    #1;
  endtask

  task automatic model_reset();
    m_fv = 0; m_line = 0; m_frame = 0;
    m_hs = 0; m_hw = 0; m_vs = 0; m_vh = 0;
    exp_q.delete();
  endtask

  task automatic set_cfg(input logic en, input int hs, input int hw, input int vs, input int vh);
    cfg_en = en;
    cfg_h_start = 16'(hs); cfg_h_width = 16'(hw);
    cfg_v_start = 16'(vs); cfg_v_height = 16'(vh);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    byte_data0 = b; rxvalid_hs0 = 1'b1;
    tick();
  endtask

  // cut >= 0 delivers only that many post-header bytes; extra bytes follow a complete packet
  task automatic send_pkt(input logic [7:0] dt, input int wc, input int cut,
                          input int gap, input int extra);
    logic [7:0] pay[$];
    int n_post, L;
    bit is_short;
    pay.delete();
    for (int i = 0; i < wc; i++) pay.push_back(8'($urandom));
    is_short = (dt[5:4] == 2'b00);
    n_post = is_short ? 0 : wc + 2;
    if (cut >= 0 && cut < n_post) n_post = cut;

    // packet-level rules
    if (dt[5:0] == DT_FS[5:0]) begin
      if (m_fv) exp_seq++;
      m_fv = 1; m_line = 0;
      m_hs = int'(cfg_h_start); m_hw = int'(cfg_h_width);
      m_vs = int'(cfg_v_start); m_vh = int'(cfg_v_height);
    end else if (dt[5:0] == DT_FE[5:0]) begin
      if (m_fv) begin m_fv = 0; m_frame++; end
      else exp_seq++;
    end else if (dt[5:0] == DT_YUV[5:0]) begin
      if (!m_fv) exp_seq++;
      else begin
        L = m_line;
        m_line++;
        if (n_post < wc + 2) exp_trunc++;
        if (L >= m_vs && L < m_vs + m_vh)
          for (int p = 0; (2*p+1 < wc) && (2*p+1 < n_post); p++)
            if (cfg_en && p >= m_hs && p < m_hs + m_hw) begin
              exp_q.push_back({pay[2*p], pay[2*p+1]});
              exp_pix++;
            end
      end
    end

    rxsync_hs0 = 1'b1; rxvalid_hs0 = 1'b0; byte_data0 = 8'($urandom);
    tick();
    rxsync_hs0 = 1'b0;
    drive_byte(dt);
    drive_byte(wc[7:0]);
    drive_byte(wc[15:8]);
    fv_pre_ecc = yuv_fv;
    drive_byte(8'($urandom));
    fv_post_ecc = yuv_fv;
    for (int i = 0; i < n_post; i++) drive_byte(i < wc ? pay[i] : 8'($urandom));
    for (int i = 0; i < extra; i++) drive_byte(8'($urandom));
    rxvalid_hs0 = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic randomize_cfg();
    set_cfg(1'b1, $urandom_range(0, 6), $urandom_range(0, 8),
            $urandom_range(0, 3), $urandom_range(0, 5));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; rxsync_hs0 = 0; rxvalid_hs0 = 0; byte_data0 = 0;
    set_cfg(1'b0, 0, 0, 0, 0);
    model_reset();
    repeat (3) tick();
    n_cmp++;
    if ({yuv_fv, yuv_lv, pix_valid, pix_data, line_cnt, frame_cnt, err_trunc, err_seq} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got fv%b lv%b pv%b pd%h lc%0d fc%0d et%b es%b, required all 0",
               yuv_fv, yuv_lv, pix_valid, pix_data, line_cnt, frame_cnt, err_trunc, err_seq);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_bad++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    int p0;
    p0 = got_pix;
    set_cfg(1'b1, 0, 4, 0, 3);
    send_pkt(DT_FS, 1, -1, 2, 0);
    n_cmp++;
    if (fv_pre_ecc !== 1'b0 || fv_post_ecc !== 1'b1) begin
      n_bad++; $display("FAIL fv_rise: got %b%b, required 01", fv_pre_ecc, fv_post_ecc);
    end
    for (int i = 0; i < 3; i++) send_pkt(DT_YUV, 8, -1, 2, 0);
    n_cmp++;
    if (line_cnt !== 16'd3) begin
      n_bad++; $display("FAIL basic_line_cnt: got %0d, required 3", line_cnt);
    end
    send_pkt(DT_FE, 1, -1, 2, 0);
    n_cmp++;
    if (fv_pre_ecc !== 1'b1 || fv_post_ecc !== 1'b0) begin
      n_bad++; $display("FAIL fv_fall: got %b%b, required 10", fv_pre_ecc, fv_post_ecc);
    end
    n_cmp++;
    if (frame_cnt !== 16'(m_frame) || m_frame != 1) begin
      n_bad++; $display("FAIL basic_frame_cnt: got %0d, required 1", frame_cnt);
    end
    n_cmp++;
    if (got_pix - p0 != 12) begin
      n_bad++; $display("FAIL basic_pix_count: got %0d, required 12", got_pix - p0);
    end
  endtask

  task automatic test_crop();
    int p0;
    p0 = got_pix;
    set_cfg(1'b1, 1, 2, 1, 1);
    send_pkt(DT_FS, 1, -1, 2, 0);
    for (int i = 0; i < 3; i++) send_pkt(DT_YUV, 8, -1, 2, 0);
    send_pkt(DT_FE, 1, -1, 3, 0);
    n_cmp++;
    if (got_pix - p0 != 2) begin
      n_bad++; $display("FAIL crop_pix_count: got %0d, required 2", got_pix - p0);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL crop_pending: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_truncation();
    int p0, t0;
    p0 = got_pix; t0 = got_trunc;
    set_cfg(1'b1, 0, 4, 0, 3);
    send_pkt(DT_FS, 1, -1, 2, 0);
    send_pkt(DT_YUV, 8, 5, 2, 0);
    n_cmp++;
    if (got_trunc - t0 != 1) begin
      n_bad++; $display("FAIL trunc_pulse: got %0d, required 1", got_trunc - t0);
    end
    n_cmp++;
    if (got_pix - p0 != 2) begin
      n_bad++; $display("FAIL trunc_pix_count: got %0d, required 2", got_pix - p0);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_bad++; $display("FAIL trunc_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    send_pkt(DT_YUV, 8, -1, 3, 0);
    n_cmp++;
    if (got_pix - p0 != 6 || got_trunc - t0 != 1) begin
      n_bad++; $display("FAIL trunc_recover: got %0d pix %0d trunc, required 6 pix 1 trunc",
                        got_pix - p0, got_trunc - t0);
    end
    n_cmp++;
    if (line_cnt !== 16'd2) begin
      n_bad++; $display("FAIL trunc_line_cnt: got %0d, required 2", line_cnt);
    end
    send_pkt(DT_FE, 1, -1, 2, 0);
  endtask

  task automatic test_seq_errors();
    int s0;
    s0 = got_seq;
    set_cfg(1'b1, 0, 4, 0, 3);
    send_pkt(DT_FS, 1, -1, 2, 0);
    send_pkt(DT_YUV, 4, -1, 2, 0);
    send_pkt(DT_FS, 1, -1, 2, 0);
    n_cmp++;
    if (got_seq - s0 != 1 || line_cnt !== 16'd0) begin
      n_bad++; $display("FAIL seq_double_fs: got %0d err %0d lines, required 1 err 0 lines",
                        got_seq - s0, line_cnt);
    end
    send_pkt(DT_FE, 1, -1, 2, 0);
    send_pkt(DT_FE, 1, -1, 2, 0);
    n_cmp++;
    if (got_seq - s0 != 2) begin
      n_bad++; $display("FAIL seq_stray_fe: got %0d, required 2", got_seq - s0);
    end
    n_cmp++;
    if (frame_cnt !== 16'(m_frame)) begin
      n_bad++; $display("FAIL seq_frame_cnt: got %0d, required %0d", frame_cnt, m_frame);
    end
  endtask

  task automatic test_yuv_outside_frame();
    int s0, p0;
    s0 = got_seq; p0 = got_pix;
    send_pkt(DT_YUV, 8, -1, 3, 0);
    n_cmp++;
    if (got_seq - s0 != 1 || got_pix != p0) begin
      n_bad++; $display("FAIL outside_frame: got %0d err %0d pix, required 1 err 0 pix",
                        got_seq - s0, got_pix - p0);
    end
    n_cmp++;
    if (line_cnt !== 16'(m_line)) begin
      n_bad++; $display("FAIL outside_line_cnt: got %0d, required %0d", line_cnt, m_line);
    end
  endtask

  task automatic test_odd_wc();
    int p0;
    set_cfg(1'b1, 0, 16, 0, 16);
    send_pkt(DT_FS, 1, -1, 2, 0);
    p0 = got_pix;
    send_pkt(DT_YUV, 7, -1, 2, 0);
    n_cmp++;
    if (got_pix - p0 != 3) begin
      n_bad++; $display("FAIL odd_wc_pix: got %0d, required 3", got_pix - p0);
    end
    cfg_h_width = 16'd1;
    p0 = got_pix;
    send_pkt(DT_YUV, 7, -1, 2, 0);
    n_cmp++;
    if (got_pix - p0 != 3) begin
      n_bad++; $display("FAIL midframe_cfg: got %0d, required 3", got_pix - p0);
    end
    send_pkt(DT_FE, 1, -1, 2, 0);
    send_pkt(DT_FS, 1, -1, 2, 0);
    p0 = got_pix;
    send_pkt(DT_YUV, 7, -1, 2, 0);
    n_cmp++;
    if (got_pix - p0 != 1) begin
      n_bad++; $display("FAIL next_frame_cfg: got %0d, required 1", got_pix - p0);
    end
    send_pkt(DT_FE, 1, -1, 2, 0);
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = got_trunc;
    set_cfg(1'b1, 0, 8, 0, 8);
    send_pkt(DT_FS, 1, -1, 0, 0);
    send_pkt(DT_YUV, 6, -1, 0, 0);
    send_pkt(DT_YUV, 6, -1, 0, 3);
    send_pkt(DT_YUV, 10, 4, 0, 0);
    send_pkt(DT_YUV, 6, -1, 3, 0);
    send_pkt(DT_FE, 1, -1, 3, 0);
    n_cmp++;
    if (got_trunc - t0 != 1) begin
      n_bad++; $display("FAIL b2b_sync_trunc: got %0d, required 1", got_trunc - t0);
    end
    n_cmp++;
    if (line_cnt !== 16'd4) begin
      n_bad++; $display("FAIL b2b_line_cnt: got %0d, required 4", line_cnt);
    end
    n_cmp++;
    if (got_pix != exp_pix || exp_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_pix: got %0d, required %0d", got_pix, exp_pix);
    end
  endtask

  task automatic test_reset_mid_packet();
    int p0, t0, s0;
    set_cfg(1'b1, 0, 4, 0, 0);
    send_pkt(DT_FS, 1, -1, 2, 0);
    p0 = got_pix; t0 = got_trunc; s0 = got_seq;
    rxsync_hs0 = 1'b1; rxvalid_hs0 = 1'b0;
    tick();
    rxsync_hs0 = 1'b0;
    drive_byte(DT_YUV); drive_byte(8'd8); drive_byte(8'd0); drive_byte(8'h5A);
    for (int i = 0; i < 3; i++) drive_byte(8'($urandom));
    rst = 1'b1;
    drive_byte(8'($urandom));
    n_cmp++;
    if ({yuv_fv, yuv_lv, pix_valid, line_cnt, frame_cnt, err_trunc, err_seq} !== '0 ||
        dbg_state !== ST_IDLE) begin
      n_bad++; $display("FAIL reset_mid_packet: got fv%b lc%0d fc%0d st%0d, required all 0",
                        yuv_fv, line_cnt, frame_cnt, dbg_state);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) drive_byte(8'($urandom));
    rxvalid_hs0 = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (got_pix != p0 || got_trunc != t0 || got_seq != s0 || dbg_state !== ST_IDLE) begin
      n_bad++; $display("FAIL reset_remainder: got %0d pix %0d trunc %0d seq st%0d, required none",
                        got_pix - p0, got_trunc - t0, got_seq - s0, dbg_state);
    end
    send_pkt(DT_FE, 1, -1, 2, 0);
    n_cmp++;
    if (got_seq - s0 != 1) begin
      n_bad++; $display("FAIL reset_closes_frame: got %0d, required 1", got_seq - s0);
    end
  endtask

  task automatic test_random();
    int kind, wc, cut;
    randomize_cfg();
    send_pkt(DT_FS, 1, -1, 2, 0);
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 99);
      if (kind < 8) begin
        randomize_cfg();
        send_pkt(DT_FS, 1, -1, $urandom_range(1, 3), 0);
      end else if (kind < 16) begin
        send_pkt(DT_FE, 1, -1, $urandom_range(1, 3), 0);
      end else if (kind < 26) begin
        send_pkt(DT_RAW8, $urandom_range(1, 12), -1, $urandom_range(1, 3), 0);
      end else begin
        cfg_en = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 4) == 0) begin
          cfg_h_start = 16'($urandom_range(0, 6));
          cfg_h_width = 16'($urandom_range(0, 8));
          cfg_v_height = 16'($urandom_range(0, 5));
        end
        wc  = $urandom_range(1, 24);
        cut = ($urandom_range(0, 6) == 0) ? $urandom_range(0, wc + 1) : -1;
        send_pkt(DT_YUV, wc, cut, $urandom_range(1, 3), $urandom_range(0, 1));
      end
    end
    send_pkt(DT_FE, 1, -1, 4, 0);
    n_cmp++;
    if (got_pix != exp_pix || exp_q.size() != 0) begin
      n_bad++; $display("FAIL rand_pix: got %0d, required %0d (%0d pending)",
                        got_pix, exp_pix, exp_q.size());
    end
    n_cmp++;
    if (got_trunc != exp_trunc) begin
      n_bad++; $display("FAIL rand_trunc: got %0d, required %0d", got_trunc, exp_trunc);
    end
    n_cmp++;
    if (got_seq != exp_seq) begin
      n_bad++; $display("FAIL rand_seq: got %0d, required %0d", got_seq, exp_seq);
    end
    n_cmp++;
    if (line_cnt !== 16'(m_line) || frame_cnt !== 16'(m_frame) || yuv_fv !== m_fv) begin
      n_bad++; $display("FAIL rand_counters: got lc%0d fc%0d fv%b, required lc%0d fc%0d fv%b",
                        line_cnt, frame_cnt, yuv_fv, m_line, m_frame, m_fv);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_frame();
    test_crop();
    test_truncation();
    test_seq_errors();
    test_yuv_outside_frame();
    test_odd_wc();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
